// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage pipe: per-operand forwarding muxes, load-use and
// load-wait stalls, EX redirect arbitration and the fence.i icache-flush sequencer.

module pipe_hazard_fwd #(
  parameter int XLEN   = 32,
  parameter int RBITS  = 5,
  parameter int WB_FWD = 1
) (
  input  logic [RBITS-1:0] rs,
  input  logic [XLEN-1:0]  rf_val,
  input  logic             ex_valid,
  input  logic             ex_wen,
  input  logic             ex_mem_ren,
  input  logic [RBITS-1:0] ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             mem_valid,
  input  logic             mem_wen,
  input  logic             mem_mem_ren,
  input  logic [RBITS-1:0] mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             wb_valid,
  input  logic             wb_wen,
  input  logic [RBITS-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  val,
  output logic             ex_rd_hit
);
  logic nz, ex_hit, mem_hit, wb_hit;

  assign nz        = |rs;
  assign ex_rd_hit = nz && (ex_rd == rs);
  // A load still in EX has no data yet; fall through to older stages (load-use stalls anyway).
  assign ex_hit    = ex_rd_hit && ex_valid && ex_wen && !ex_mem_ren;
  assign mem_hit   = nz && mem_valid && mem_wen && (mem_rd == rs);
  assign wb_hit    = (WB_FWD != 0) && nz && wb_valid && wb_wen && (wb_rd == rs);

  always_comb begin
    if (ex_hit)       val = ex_result;
    else if (mem_hit) val = mem_mem_ren ? mem_rdata : mem_result;
    else if (wb_hit)  val = wb_data;
    else              val = rf_val;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int XLEN   = 32,
  parameter int RBITS  = 5,
  parameter int WB_FWD = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RBITS-1:0] id_rs1,
  input  logic [RBITS-1:0] id_rs2,
  input  logic [XLEN-1:0]  id_rs1_val,
  input  logic [XLEN-1:0]  id_rs2_val,
  input  logic             ex_valid,
  input  logic             ex_wen,
  input  logic             ex_mem_ren,
  input  logic [RBITS-1:0] ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             mem_valid,
  input  logic             mem_wen,
  input  logic             mem_mem_ren,
  input  logic [RBITS-1:0] mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_rdata_valid,
  input  logic             wb_valid,
  input  logic             wb_wen,
  input  logic [RBITS-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             branch_taken,
  input  logic             jump_flag,
  input  logic             mret_flag,
  input  logic             ecall_flag,
  input  logic             fence_i_flag,
  input  logic [XLEN-1:0]  ex_target,
  input  logic [XLEN-1:0]  mepc,
  input  logic [XLEN-1:0]  mtvec,
  input  logic [XLEN-1:0]  fence_pc,
  input  logic             icache_clr_ack,
  output logic [XLEN-1:0]  ex_rs1_in,
  output logic [XLEN-1:0]  ex_rs2_in,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_bubble,
  output logic             pipe_freeze,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             icache_clr_req,
  output logic             ctrl_busy
);
  localparam int NUM_OPS = 2;

  typedef enum logic [1:0] {IDLE, CLR, REDIR} state_t;
  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] pc;
  } redir_t;

  logic [NUM_OPS-1:0][RBITS-1:0] op_rs;
  logic [NUM_OPS-1:0][XLEN-1:0]  op_rf, op_val;
  logic [NUM_OPS-1:0]            op_ex_hit;

  state_t          state;
  logic [XLEN-1:0] fence_tgt;
  logic            load_use, load_wait, idle, fence_start, evt_any, evt_redir, fsm_redir;
  redir_t          redir;

  assign op_rs = {id_rs2, id_rs1};
  assign op_rf = {id_rs2_val, id_rs1_val};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    pipe_hazard_fwd #(.XLEN(XLEN), .RBITS(RBITS), .WB_FWD(WB_FWD)) u_fwd (
      .rs          (op_rs[i]),
      .rf_val      (op_rf[i]),
      .ex_valid    (ex_valid),
      .ex_wen      (ex_wen),
      .ex_mem_ren  (ex_mem_ren),
      .ex_rd       (ex_rd),
      .ex_result   (ex_result),
      .mem_valid   (mem_valid),
      .mem_wen     (mem_wen),
      .mem_mem_ren (mem_mem_ren),
      .mem_rd      (mem_rd),
      .mem_result  (mem_result),
      .mem_rdata   (mem_rdata),
      .wb_valid    (wb_valid),
      .wb_wen      (wb_wen),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .val         (op_val[i]),
      .ex_rd_hit   (op_ex_hit[i])
    );
  end

  assign ex_rs1_in = op_val[0];
  assign ex_rs2_in = op_val[1];

  assign load_use    = id_valid && ex_valid && ex_mem_ren && (|op_ex_hit);
  assign load_wait   = mem_valid && mem_mem_ren && !mem_rdata_valid;
  assign idle        = (state == IDLE);
  assign fence_start = idle && ex_valid && fence_i_flag && !load_wait;
  assign evt_any     = jump_flag || branch_taken || mret_flag || ecall_flag;
  assign evt_redir   = idle && !load_wait && !fence_start && evt_any;
  assign fsm_redir   = (state == REDIR) && !load_wait;

  always_comb begin
    redir.vld = evt_redir || fsm_redir;
    if (state == REDIR)   redir.pc = fence_tgt;
    else if (jump_flag)   redir.pc = ex_target;
    else if (branch_taken) redir.pc = ex_target;
    else if (mret_flag)   redir.pc = mepc;
    else                  redir.pc = mtvec;
  end

  assign redirect_valid = redir.vld;
  assign redirect_pc    = redir.pc;
  assign pipe_freeze    = load_wait;
  assign if_stall       = load_use || load_wait || fence_start || (state == CLR);
  assign id_stall       = load_use || load_wait || (state == CLR);
  // A frozen pipe holds every stage, so nothing may be squashed into EX.
  assign ex_bubble      = !load_wait && (load_use || evt_redir || fence_start || !idle);

  // Flush sequencer; a frozen pipe holds it in place, acks outside CLR are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      fence_tgt      <= '0;
      icache_clr_req <= 1'b0;
      ctrl_busy      <= 1'b0;
    end else if (!load_wait) begin
      case (state)
        IDLE: if (fence_start) begin
          state          <= CLR;
          fence_tgt      <= fence_pc + XLEN'(4);
          icache_clr_req <= 1'b1;
          ctrl_busy      <= 1'b1;
        end
        CLR: if (icache_clr_ack) begin
          state          <= REDIR;
          icache_clr_req <= 1'b0;
        end
        REDIR: begin
          state     <= IDLE;
          ctrl_busy <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          icache_clr_req <= 1'b0;
          ctrl_busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
